// File: rtl/uart_fifo_if.sv
// UART-side handshake bundle between uart_fifo and the buart transmitter/receiver pair.
// The master modport is the FIFO side; the slave modport is the UART side.
interface uart_fifo_if;
  logic       u_wr;
  logic [7:0] u_tx_data;
  logic       u_busy;
  logic       u_valid;
  logic [7:0] u_rx_data;
  logic       u_rd;

  modport master (
    output u_wr,
    output u_tx_data,
    output u_rd,
    input  u_busy,
    input  u_valid,
    input  u_rx_data
  );

  modport slave (
    input  u_wr,
    input  u_tx_data,
    input  u_rd,
    output u_busy,
    output u_valid,
    output u_rx_data
  );
endinterface

// File: rtl/uart_fifo.sv
// Byte-buffering stage between host logic and the buart UART pair: a TX FIFO feeding
// the transmitter through wr/busy, and an RX FIFO that always drains the receiver.
module uart_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  tx_wr,
  input  logic [7:0]            tx_data,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic                  tx_ovf,
  input  logic                  rx_rd,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic                  rx_ovf,
  input  logic                  ovf_clr,
  uart_fifo_if.master           u
);

  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KICK = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

  function automatic logic [DEPTH_LOG2:0] level_next(
    input logic [DEPTH_LOG2:0] lvl,
    input logic                push,
    input logic                pop
  );
    logic [DEPTH_LOG2:0] res;
    case ({push, pop})
      2'b10:   res = lvl + LVL_ONE;
      2'b01:   res = lvl - LVL_ONE;
      default: res = lvl;
    endcase
    return res;
  endfunction

  function automatic logic flag_next(
    input logic cur,
    input logic clr,
    input logic set
  );
    logic res;
    if (clr) begin
      res = 1'b0;
    end else if (set) begin
      res = 1'b1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // TX storage and control
  logic [7:0]            tx_mem_r [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] tx_wp_r;
  logic [DEPTH_LOG2-1:0] tx_rp_r;
  logic [DEPTH_LOG2:0]   tx_level_r;
  logic                  tx_ovf_r;
  logic                  tx_full_s;
  logic                  tx_push_s;
  logic                  tx_pop_s;
  logic                  tx_drop_s;
  tx_state_e             tx_state_r;
  tx_state_e             tx_state_s;
  logic                  u_wr_r;
  logic                  u_wr_s;
  logic [7:0]            u_tx_data_r;
  logic [7:0]            u_tx_data_s;

  // RX storage and control
  logic [7:0]            rx_mem_r [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] rx_wp_r;
  logic [DEPTH_LOG2-1:0] rx_rp_r;
  logic [DEPTH_LOG2:0]   rx_level_r;
  logic                  rx_ovf_r;
  logic                  rx_full_s;
  logic                  rx_push_s;
  logic                  rx_pop_s;
  logic                  rx_drop_s;
  logic                  u_rd_s;

  // TX push/pop qualification; the head leaves the FIFO during the KICK cycle
  always_comb begin
    tx_full_s = (tx_level_r == LVL_FULL);
    tx_pop_s  = (tx_state_r == ST_KICK);
    tx_push_s = tx_wr & (~tx_full_s | tx_pop_s);
    tx_drop_s = tx_wr & tx_full_s & ~tx_pop_s;
  end

  // TX state machine next-state and registered-output staging
  always_comb begin
    tx_state_s  = tx_state_r;
    u_wr_s      = 1'b0;
    u_tx_data_s = u_tx_data_r;
    case (tx_state_r)
      ST_IDLE: begin
        if ((tx_level_r != LVL_ZERO) && !u.u_busy) begin
          tx_state_s  = ST_KICK;
          u_wr_s      = 1'b1;
          u_tx_data_s = tx_mem_r[tx_rp_r];
        end else begin
          tx_state_s  = ST_IDLE;
        end
      end
      ST_KICK: tx_state_s = ST_WAIT;
      // Blanking cycle so the transmitter can raise busy after the strobe.
      ST_WAIT: tx_state_s = ST_IDLE;
      default: tx_state_s = ST_IDLE;
    endcase
  end

  // TX state, pointers, level, overflow flag and transmitter strobe
  always_ff @(posedge clk) begin
    if (!resetq) begin
      tx_state_r  <= ST_IDLE;
      tx_wp_r     <= {DEPTH_LOG2{1'b0}};
      tx_rp_r     <= {DEPTH_LOG2{1'b0}};
      tx_level_r  <= LVL_ZERO;
      tx_ovf_r    <= 1'b0;
      u_wr_r      <= 1'b0;
      u_tx_data_r <= 8'h00;
    end else begin
      tx_state_r  <= tx_state_s;
      u_wr_r      <= u_wr_s;
      u_tx_data_r <= u_tx_data_s;
      tx_level_r  <= level_next(tx_level_r, tx_push_s, tx_pop_s);
      tx_ovf_r    <= flag_next(tx_ovf_r, ovf_clr, tx_drop_s);
      if (tx_push_s) begin
        tx_wp_r <= tx_wp_r + PTR_ONE;
      end
      if (tx_pop_s) begin
        tx_rp_r <= tx_rp_r + PTR_ONE;
      end
    end
  end

  // TX byte storage
  always_ff @(posedge clk) begin
    if (resetq && tx_push_s) begin
      tx_mem_r[tx_wp_r] <= tx_data;
    end
  end

  // RX side: the receiver is drained whenever it has a byte, full or not
  always_comb begin
    u_rd_s    = resetq & u.u_valid;
    rx_full_s = (rx_level_r == LVL_FULL);
    rx_pop_s  = rx_rd & (rx_level_r != LVL_ZERO);
    rx_push_s = u_rd_s & (~rx_full_s | rx_pop_s);
    rx_drop_s = u_rd_s & rx_full_s & ~rx_pop_s;
  end

  // RX pointers, level and overflow flag
  always_ff @(posedge clk) begin
    if (!resetq) begin
      rx_wp_r    <= {DEPTH_LOG2{1'b0}};
      rx_rp_r    <= {DEPTH_LOG2{1'b0}};
      rx_level_r <= LVL_ZERO;
      rx_ovf_r   <= 1'b0;
    end else begin
      rx_level_r <= level_next(rx_level_r, rx_push_s, rx_pop_s);
      rx_ovf_r   <= flag_next(rx_ovf_r, ovf_clr, rx_drop_s);
      if (rx_push_s) begin
        rx_wp_r <= rx_wp_r + PTR_ONE;
      end
      if (rx_pop_s) begin
        rx_rp_r <= rx_rp_r + PTR_ONE;
      end
    end
  end

  // RX byte storage
  always_ff @(posedge clk) begin
    if (resetq && rx_push_s) begin
      rx_mem_r[rx_wp_r] <= u.u_rx_data;
    end
  end

  assign tx_full     = tx_full_s;
  assign tx_level    = tx_level_r;
  assign tx_ovf      = tx_ovf_r;
  assign rx_data     = rx_mem_r[rx_rp_r];
  assign rx_valid    = (rx_level_r != LVL_ZERO);
  assign rx_level    = rx_level_r;
  assign rx_ovf      = rx_ovf_r;
  assign u.u_wr      = u_wr_r;
  assign u.u_tx_data = u_tx_data_r;
  assign u.u_rd      = u_rd_s;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo: TX latency/pacing/overflow, RX wrap,
// RX full with simultaneous pop, and reset during a transmitter kick.
module tb_uart_fifo;
  logic       clk = 1'b0;
  logic       resetq;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full;
  logic [4:0] tx_level;
  logic       tx_ovf;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_level;
  logic       rx_ovf;
  logic       ovf_clr;
  logic       busy_hold;
  int         busy_cnt;
  int         busy_len;
  int         cyc;
  logic       prev_wr;
  int         n_checks;
  int         n_pass;
  logic [7:0] tx_seen[$];
  int         tx_cyc[$];
  logic [7:0] rx_seen[$];

  uart_fifo_if bus();

  uart_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .tx_level (tx_level),
    .tx_ovf   (tx_ovf),
    .rx_rd    (rx_rd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_level (rx_level),
    .rx_ovf   (rx_ovf),
    .ovf_clr  (ovf_clr),
    .u        (bus.master)
  );

  assign bus.u_busy = busy_hold | (busy_cnt != 0);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model and strobe monitor: busy rises in the strobe cycle for busy_len cycles
  always @(negedge clk) begin
    if (bus.u_wr) begin
      tx_seen.push_back(bus.u_tx_data);
      tx_cyc.push_back(cyc);
      check("wr_adjacent", prev_wr, 1'b0);
      check("wr_while_busy", bus.u_busy, 1'b0);
      if (busy_len != 0) busy_cnt = busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt = busy_cnt - 1;
    end
    prev_wr = bus.u_wr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b;
    int k;
    cyc = 0; n_checks = 0; n_pass = 0; prev_wr = 1'b0;
    busy_cnt = 0; busy_len = 0; busy_hold = 1'b0;
    resetq = 1'b0; tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; ovf_clr = 1'b0;
    bus.u_valid = 1'b1; bus.u_rx_data = 8'h99;

    // Reset state, with the receiver offering a byte that must not be read
    repeat (3) tick();
    @(negedge clk);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_tx_level", tx_level, 5'd0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_level", rx_level, 5'd0);
    check("rst_ovf", {tx_ovf, rx_ovf}, 2'b00);
    check("rst_u_wr", bus.u_wr, 1'b0);
    check("rst_u_tx_data", bus.u_tx_data, 8'h00);
    check("rst_u_rd_gated", bus.u_rd, 1'b0);
    tick();
    bus.u_valid = 1'b0;
    resetq = 1'b1;
    tick();

    // TX latency: push at cycle N, strobe in N+2 only
    tx_seen.delete(); tx_cyc.delete();
    tx_wr = 1'b1; tx_data = 8'h55;
    @(negedge clk); check("lat_n_wr", bus.u_wr, 1'b0);
    tick(); tx_wr = 1'b0;
    @(negedge clk); check("lat_n1_wr", bus.u_wr, 1'b0); check("lat_n1_level", tx_level, 5'd1);
    tick();
    @(negedge clk); check("lat_n2_wr", bus.u_wr, 1'b1); check("lat_n2_data", bus.u_tx_data, 8'h55);
    tick();
    @(negedge clk); check("lat_n3_wr", bus.u_wr, 1'b0); check("lat_n3_level", tx_level, 5'd0);
    repeat (4) tick();
    check("lat_count", tx_seen.size(), 32'd1);

    // TX pacing with a 10-cycle busy after each strobe
    tx_seen.delete(); tx_cyc.delete();
    busy_len = 10;
    for (int i = 0; i < 3; i++) begin
      tx_wr = 1'b1; tx_data = 8'(i + 1);
      tick();
    end
    tx_wr = 1'b0;
    for (k = 0; k < 200 && tx_seen.size() < 3; k++) tick();
    check("pace_count", tx_seen.size(), 32'd3);
    if (tx_seen.size() >= 3) begin
      for (int i = 0; i < 3; i++) check("pace_data", tx_seen[i], 8'(i + 1));
      check("pace_gap1", tx_cyc[1] - tx_cyc[0], 32'd11);
      check("pace_gap2", tx_cyc[2] - tx_cyc[1], 32'd11);
    end
    busy_len = 0;
    repeat (15) tick();

    // TX overflow with the transmitter held busy
    tx_seen.delete(); tx_cyc.delete();
    busy_hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_wr = 1'b1; tx_data = 8'(8'h10 + i);
      tick();
    end
    tx_wr = 1'b0;
    @(negedge clk);
    check("ovf_full", tx_full, 1'b1); check("ovf_level16", tx_level, 5'd16); check("ovf_not_yet", tx_ovf, 1'b0);
    tick(); tx_wr = 1'b1; tx_data = 8'hEE;
    tick(); tx_wr = 1'b0;
    @(negedge clk);
    check("ovf_set", tx_ovf, 1'b1); check("ovf_level_hold", tx_level, 5'd16);
    tick(); ovf_clr = 1'b1; tx_wr = 1'b1; tx_data = 8'hEF;
    tick(); ovf_clr = 1'b0; tx_wr = 1'b0;
    @(negedge clk);
    check("ovf_clr_priority", tx_ovf, 1'b0);
    tick(); busy_hold = 1'b0;
    for (k = 0; k < 100 && tx_seen.size() < 16; k++) tick();
    check("ovf_drain_count", tx_seen.size(), 32'd16);
    if (tx_seen.size() >= 16) begin
      for (int i = 0; i < 16; i++) check("ovf_drain_data", tx_seen[i], 8'(8'h10 + i));
    end
    repeat (4) tick();
    check("ovf_drain_level", tx_level, 5'd0);
    check("ovf_drain_extra", tx_seen.size(), 32'd16);

    // RX path across pointer wrap with continuous host pops
    rx_seen.delete();
    rx_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.u_valid = 1'b1; bus.u_rx_data = 8'(8'hA0 + i);
      @(negedge clk);
      check("rxw_u_rd", bus.u_rd, 1'b1);
      if (i == 0) check("rxw_first_empty", rx_valid, 1'b0);
      if (i == 1) begin
        check("rxw_first_valid", rx_valid, 1'b1);
        check("rxw_first_data", rx_data, 8'hA0);
      end
      if (rx_valid) rx_seen.push_back(rx_data);
      tick();
    end
    bus.u_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rx_valid) rx_seen.push_back(rx_data);
      tick();
    end
    check("rxw_u_rd_idle", bus.u_rd, 1'b0);
    rx_rd = 1'b0;
    check("rxw_count", rx_seen.size(), 32'd40);
    if (rx_seen.size() >= 40) begin
      for (int i = 0; i < 40; i++) check("rxw_data", rx_seen[i], 8'(8'hA0 + i));
    end
    check("rxw_ovf", rx_ovf, 1'b0);
    check("rxw_level", rx_level, 5'd0);

    // RX full, then a receive with and without a simultaneous host pop
    for (int i = 0; i < 16; i++) begin
      bus.u_valid = 1'b1; bus.u_rx_data = 8'(8'h30 + i);
      tick();
    end
    bus.u_valid = 1'b0;
    @(negedge clk);
    check("rxf_level16", rx_level, 5'd16); check("rxf_head", rx_data, 8'h30); check("rxf_ovf0", rx_ovf, 1'b0);
    tick(); bus.u_valid = 1'b1; bus.u_rx_data = 8'h40; rx_rd = 1'b1;
    tick(); bus.u_valid = 1'b0; rx_rd = 1'b0;
    @(negedge clk);
    check("rxf_pop_level", rx_level, 5'd16); check("rxf_pop_ovf", rx_ovf, 1'b0); check("rxf_pop_head", rx_data, 8'h31);
    tick(); bus.u_valid = 1'b1; bus.u_rx_data = 8'h41;
    tick(); bus.u_valid = 1'b0;
    @(negedge clk);
    check("rxf_drop_ovf", rx_ovf, 1'b1); check("rxf_drop_level", rx_level, 5'd16);
    tick(); rx_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(8'h31 + i) : 8'h40;
      @(negedge clk);
      check("rxf_drain", rx_data, exp_b);
      tick();
    end
    rx_rd = 1'b0;
    @(negedge clk);
    check("rxf_empty", rx_valid, 1'b0);
    tick(); ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    @(negedge clk);
    check("rxf_ovf_clr", rx_ovf, 1'b0);

    // Reset during a KICK with five bytes queued and one RX byte held
    tick();
    tx_seen.delete(); tx_cyc.delete();
    busy_hold = 1'b1;
    bus.u_valid = 1'b1; bus.u_rx_data = 8'h77;
    tick(); bus.u_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_wr = 1'b1; tx_data = 8'(8'h60 + i);
      tick();
    end
    tx_wr = 1'b0; busy_hold = 1'b0;
    @(negedge clk);
    for (k = 0; k < 20 && !bus.u_wr; k++) @(negedge clk);
    check("mid_kick_seen", bus.u_wr, 1'b1);
    check("mid_kick_level", tx_level, 5'd5);
    check("mid_rx_valid", rx_valid, 1'b1);
    resetq = 1'b0;
    tick(); bus.u_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_u_wr", bus.u_wr, 1'b0);
    check("mid_rst_tx_level", tx_level, 5'd0);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_u_rd", bus.u_rd, 1'b0);
    tick(); bus.u_valid = 1'b0; resetq = 1'b1;
    repeat (10) tick();
    check("mid_post_count", tx_seen.size(), 32'd1);
    if (tx_seen.size() >= 1) check("mid_post_data", tx_seen[0], 8'h60);
    check("mid_post_level", tx_level, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Byte-buffering stage between host logic and the buart UART pair.
- TX side: queues host bytes and feeds the transmitter through its wr/busy handshake.
- RX side: drains the receiver through its valid/rd handshake and queues received bytes for the host.

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of the entries per FIFO (16 TX, 16 RX).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port resetq  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port tx_wr  input  1  host push strobe, one byte per cycle high.
REQ-005 SHALL have port tx_data  input  8  byte pushed when tx_wr is high.
REQ-006 SHALL have port tx_full  output  1  TX FIFO holds 2**DEPTH_LOG2 entries.
REQ-007 SHALL have port tx_level  output  DEPTH_LOG2+1  TX FIFO occupancy.
REQ-008 SHALL have port tx_ovf  output  1  sticky flag: a TX push was dropped.
REQ-009 SHALL have port rx_rd  input  1  host pop strobe.
REQ-010 SHALL have port rx_data  output  8  head of RX FIFO (show-ahead).
REQ-011 SHALL have port rx_valid  output  1  RX FIFO non-empty.
REQ-012 SHALL have port rx_level  output  DEPTH_LOG2+1  RX FIFO occupancy.
REQ-013 SHALL have port rx_ovf  output  1  sticky flag: a received byte was dropped.
REQ-014 SHALL have port ovf_clr  input  1  clears tx_ovf and rx_ovf.
REQ-015 SHALL have port u_wr  output  1  transmitter write strobe.
REQ-016 SHALL have port u_tx_data  output  8  transmitter byte, valid while u_wr is high.
REQ-017 SHALL have port u_busy  input  1  transmitter busy.
REQ-018 SHALL have port u_valid  input  1  receiver has a byte.
REQ-019 SHALL have port u_rx_data  input  8  receiver byte.
REQ-020 SHALL have port u_rd  output  1  receiver read strobe.

Function
REQ-021 SHALL implement each FIFO as a circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo 2**DEPTH_LOG2 and a separate DEPTH_LOG2+1-bit level.
REQ-022 SHALL apply the same push rule to both FIFOs: a push is accepted when the FIFO is not full at the start of the cycle, or when a pop of that FIFO occurs in the same cycle (level unchanged).
REQ-023 SHALL drop a TX push made while full with no simultaneous pop, leave FIFO contents unchanged, and set tx_ovf on the next edge.
REQ-024 SHALL ignore rx_rd while the RX FIFO is empty; the pointers and level do not change.
REQ-025 SHALL drive u_rd combinationally equal to u_valid, so the receiver is always drained and keeps receiving.
REQ-026 SHALL push u_rx_data into the RX FIFO in the same cycle u_rd is high, under the rule of REQ-022.
REQ-027 SHALL drop the received byte when the RX FIFO is full with no simultaneous rx_rd, and set rx_ovf on the next edge.
REQ-028 SHALL raise rx_valid in the cycle after u_valid is sampled high with the RX FIFO empty; rx_data equals that byte.
REQ-029 SHALL run a TX state machine with states IDLE, KICK and WAIT.
- IDLE->KICK when TX level is nonzero and u_busy is low.
- KICK: u_wr high for exactly one cycle; u_tx_data = head entry; the head is popped in the same cycle.
- KICK->WAIT unconditionally.
- WAIT->IDLE unconditionally; this blanking cycle lets u_busy rise after the strobe.
REQ-030 SHALL register u_wr and u_tx_data as flops, so a push at cycle N into an empty FIFO with u_busy low gives u_wr high in cycle N+2.
REQ-031 SHALL never assert u_wr in two consecutive cycles, and never while u_busy is high.
REQ-032 SHALL give ovf_clr priority over a same-cycle set: the flag clears, and a drop in that cycle is not recorded.

Reset
REQ-033 SHALL, while resetq is low at a rising edge, apply the following on that edge:
- clear all pointers and levels;
- set tx_ovf=0, rx_ovf=0, u_wr=0, u_tx_data=0;
- return the TX state machine to IDLE.
REQ-034 SHALL, as a consequence, hold tx_full=0, tx_level=0, rx_valid=0 and rx_level=0 after reset.
REQ-035 SHALL discard all FIFO contents on a reset during operation, including a pending KICK, and issue no u_wr until a new push occurs after resetq rises.
REQ-036 SHALL gate u_rd with resetq: it is 0 while resetq is low.

Verification
REQ-037 SHALL cover TX latency: after reset, push 0x55 at cycle N with u_busy=0 -> u_wr=1 with u_tx_data=0x55 only in cycle N+2, then tx_level=0.
REQ-038 SHALL cover TX pacing: push 0x01,0x02,0x03 back to back, with a busy model high for 10 cycles after each u_wr -> three u_wr pulses in order, each issued only after busy falls, never adjacent.
REQ-039 SHALL cover TX overflow: hold u_busy=1, push 17 bytes -> tx_full=1, tx_level=16, tx_ovf=1; pulse ovf_clr -> tx_ovf=0.
REQ-040 SHALL cover RX path and wrap: deliver 40 bytes via u_valid while the host pops continuously -> u_rd mirrors u_valid, bytes emerge in order across pointer wrap, rx_ovf=0.
REQ-041 SHALL cover RX full with simultaneous pop: fill RX to 16, then u_valid=1 with rx_rd=1 in the same cycle -> byte accepted, rx_level stays 16, rx_ovf=0; the same event with rx_rd=0 -> rx_ovf=1.
REQ-042 SHALL cover reset mid-transfer: assert resetq=0 during KICK with 5 bytes queued -> next cycle u_wr=0, tx_level=0, rx_valid=0.
